// File: rtl/pmp_csr_bank.sv
// Machine-mode PMP cfg/addr CSR bank with lock, TOR-lock, read-only and WARL write rules.
// Registered response one cycle after req_i; always ready, so back-to-back requests need no backpressure.
module pmp_csr_bank #(
  parameter int unsigned       NrPMPEntries     = 8,
  parameter int unsigned       XLEN             = 32,
  parameter logic [15:0][63:0] PMPCfgRstVal     = '0,
  parameter logic [15:0][63:0] PMPAddrRstVal    = '0,
  parameter logic [15:0]       PMPEntryReadOnly = '0
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   req_i,
  input  logic [1:0]             op_i,
  input  logic [11:0]            addr_i,
  input  logic [XLEN-1:0]        wdata_i,
  output logic                   ack_o,
  output logic [XLEN-1:0]        rdata_o,
  output logic                   err_o,
  output logic [15:0][7:0]       pmpcfg_o,
  output logic [15:0][31:0]      pmpaddr_o
);

  localparam logic [1:0] OpRead  = 2'b00;
  localparam logic [1:0] OpWrite = 2'b01;
  localparam logic [1:0] OpSet   = 2'b10;
  localparam logic [1:0] OpClear = 2'b11;

  logic [15:0][7:0]  cfg_q, cfg_d;
  logic [15:0][31:0] addr_q, addr_d;
  logic              ack_q, err_q;
  logic [XLEN-1:0]   rdata_q;

  logic              is_cfg, is_addr, hit;
  logic [XLEN-1:0]   old_val, cand;
  logic [15:0]       tor_locked;
  logic [7:0]        cand_byte;

  // pmpcfg0-3 live at 0x3A0-0x3A3, pmpaddr0-15 at 0x3B0-0x3BF
  assign is_cfg  = (addr_i[11:2] == 10'h0E8);
  assign is_addr = (addr_i[11:4] == 8'h3B);
  assign hit     = is_cfg | is_addr;

  // Unimplemented entries hold constant zero, so reads of them fall out as 0
  always_comb begin
    old_val = '0;
    if (is_cfg) begin
      for (int k = 0; k < 4; k++) begin
        old_val[8*k +: 8] = cfg_q[{addr_i[1:0], 2'(k)}];
      end
    end else if (is_addr) begin
      old_val = addr_q[addr_i[3:0]];
    end
  end

  always_comb begin
    case (op_i)
      OpWrite: cand = wdata_i;
      OpSet:   cand = old_val | wdata_i;
      OpClear: cand = old_val & ~wdata_i;
      default: cand = old_val;
    endcase
  end

  // A locked TOR entry i+1 also freezes the lower bound held in pmpaddr[i]
  always_comb begin
    tor_locked = '0;
    for (int i = 0; i < 15; i++) begin
      tor_locked[i] = (i + 1 < NrPMPEntries) && cfg_q[i+1][7] && (cfg_q[i+1][4:3] == 2'b01);
    end
  end

  always_comb begin
    cfg_d     = cfg_q;
    addr_d    = addr_q;
    cand_byte = '0;
    if (req_i && (op_i != OpRead)) begin
      for (int i = 0; i < 16; i++) begin
        cand_byte = cand[8*(i%4) +: 8];
        if (is_cfg && (addr_i[1:0] == 2'(i/4)) && (i < NrPMPEntries) &&
            !cfg_q[i][7] && !PMPEntryReadOnly[i] && !(!cand_byte[0] && cand_byte[1])) begin
          cfg_d[i] = cand_byte & 8'h9F;
        end
        if (is_addr && (addr_i[3:0] == 4'(i)) && (i < NrPMPEntries) &&
            !cfg_q[i][7] && !PMPEntryReadOnly[i] && !tor_locked[i]) begin
          addr_d[i] = cand[31:0];
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 16; i++) begin
        cfg_q[i]  <= (i < NrPMPEntries) ? (PMPCfgRstVal[i][7:0] & 8'h9F) : 8'h00;
        addr_q[i] <= (i < NrPMPEntries) ? PMPAddrRstVal[i][31:0] : 32'h0;
      end
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      cfg_q  <= cfg_d;
      addr_q <= addr_d;
      ack_q  <= req_i;
      err_q  <= req_i & ~hit;
      if (req_i) begin
        rdata_q <= hit ? old_val : '0;
      end
    end
  end

  assign ack_o     = ack_q;
  assign err_o     = err_q;
  assign rdata_o   = rdata_q;
  assign pmpcfg_o  = cfg_q;
  assign pmpaddr_o = addr_q;

endmodule
